mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative signed multiply/divide engine that sits downstream of the datapath register file/bus and produces the 64-bit result written into the HI and LO registers.
- The control unit pulses `start` with operands taken from the bus (A = RA contents, B = bus value) and waits for `done`.
- Radix-2 Booth multiplication and restoring division on magnitudes, followed by a sign-fix step.
- One operation in flight at a time.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk       in   1      system clock, rising edge
- clr       in   1      synchronous, active-high reset
- start     in   1      request pulse; sampled only when busy=0
- op        in   1      0 = MUL (signed), 1 = DIV (signed); latched with start
- a         in   WIDTH  multiplicand / dividend; latched with start
- b         in   WIDTH  multiplier / divisor; latched with start
- busy      out  1      high from the edge accepting start until the result edge
- done      out  1      one-cycle pulse; hi/lo valid from this cycle
- hi        out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
- lo        out  WIDTH  MUL: product[W-1:0]; DIV: quotient
- div_zero  out  1      present only with MULDIV_DIVZERO_EN

Behaviour:
- Clock and reset: one clock, clk; reset clr is synchronous and active-high. On clr: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, div_zero=0. clr wins over start in the same cycle. clr mid-operation aborts the operation and discards partial results.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE: when start=1, latch op/a/b. busy=1 after the edge.
- PREP (1 cycle), MUL: clear the (WIDTH+1)-bit accumulator, load the multiplier with Q[-1]=0.
- PREP, DIV: compute |a| and |b|, record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
- RUN (exactly WIDTH cycles; counter counts 0..WIDTH-1, then exit).
  - MUL: Booth step on the {Q0,Q-1} pair, add/sub a sign-extended to W+1 bits, then arithmetic shift right of {acc,Q,Q-1}. The W+1 accumulator guarantees a correct result for a = 0x80000000.
  - DIV: shift {R,Q} left, trial subtract |b|; if non-negative keep it and set Q0=1, else restore.
- FIX (1 cycle).
  - MUL: no correction.
  - DIV: negate Q if sign_q; negate R if sign_r.
  - Write hi/lo; done=1 and busy=0 after this edge.
- Latency: start accepted at edge E0; hi/lo/done update at edge E(WIDTH+2), i.e. E34 for WIDTH=32. done is high for exactly one cycle. hi/lo hold their value until the next result edge or clr.
- start while busy=1 is ignored: no effect on the operands or the result.
- start during the done cycle is accepted, since busy=0 then.
- Arithmetic rules:
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero gives lo=0xFFFFFFFF, hi=a (original signed dividend).
- a/b may change after the start cycle without affecting the result.

Optional Feature:
- Macro: MULDIV_DIVZERO_EN.
- With the macro:
  - Adds the div_zero port.
  - DIV with b=0 goes IDLE -> FIX directly, skipping PREP/RUN. hi/lo/done update at E1.
  - div_zero=1 for the same cycle as done. It is 0 for all other results.
- Without the macro:
  - No div_zero port.
  - Divide by zero runs the full WIDTH+2 latency and produces the same hi/lo values defined above.

Decomposition:
- Shared package cpu_pkg holds:
  - MD_OP_MUL=1'b0 and MD_OP_DIV=1'b1
  - the md_state_t enum (IDLE, PREP, RUN, FIX)
  - the default datapath width constant (32)
- One natural sub-module: muldiv_step, a combinational single-iteration unit (Booth add/shift or restoring subtract/shift selected by op). mul_div_unit keeps the FSM, counter, sign registers and output registers.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> at E34: lo=0xFFFFFFEB, hi=0xFFFFFFFF, done pulse 1 cycle, busy low.
- MUL a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; MUL 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=100, b=0:
  - without the macro -> lo=0xFFFFFFFF, hi=0x64 at E34;
  - with MULDIV_DIVZERO_EN -> same values at E1 with div_zero=1.
- MUL 5*6 started, second start with 9*9 pulsed at E10 -> result lo=30, hi=0 at E34, and only one done pulse.
- DIV started, clr at E15 -> busy=0, hi=lo=0, no done. A new start at E17 completes normally at E51.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multiply/divide datapath.
package cpu_pkg;

    localparam int unsigned MD_DATA_W = 32;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        RUN,
        FIX
    } md_state_t;

endpackage

// File: rtl/mul_div_step.sv
// Single combinational iteration: Booth add/shift for MUL, restoring
// subtract/shift for DIV. Module name is muldiv_step.
module muldiv_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MD_DATA_W
) (
    input  logic             op_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;

    always_comb begin
        booth_sum = acc_i;
        rem_sh    = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
        trial     = {1'b0, rem_sh} - {1'b0, m_i};
        acc_o     = acc_i;
        q_o       = q_i;
        qm1_o     = 1'b0;

        if (op_i == MD_OP_MUL) begin
            case ({q_i[0], qm1_i})
                2'b01:   booth_sum = acc_i + m_i;
                2'b10:   booth_sum = acc_i - m_i;
                default: booth_sum = acc_i;
            endcase
            // Arithmetic shift right of {acc, Q, Q-1}.
            acc_o = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_o   = {booth_sum[0], q_i[WIDTH-1:1]};
            qm1_o = q_i[0];
        end else if (!trial[WIDTH+1]) begin
            acc_o = trial[WIDTH:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = rem_sh;
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide producing HI/LO. Optional MULDIV_DIVZERO_EN
// adds a div_zero flag and a fast path for division by zero.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MD_DATA_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             div_zero
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    md_state_t        state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic             step_qm1;

    assign a_abs = a_q[WIDTH-1] ? -a_q : a_q;
    assign b_abs = b_q[WIDTH-1] ? -b_q : b_q;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .qm1_o (step_qm1)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_EN
        dz_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = PREP;
`ifdef MULDIV_DIVZERO_EN
                    if (op == MD_OP_DIV && b == '0) state_d = FIX;
`endif
                end
            end
            PREP: begin
                acc_d    = '0;
                qm1_d    = 1'b0;
                cnt_d    = '0;
                sign_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                sign_r_d = a_q[WIDTH-1];
                if (op_q == MD_OP_MUL) begin
                    q_d = b_q;
                    m_d = {a_q[WIDTH-1], a_q};
                end else begin
                    q_d = a_abs;
                    m_d = {1'b0, b_abs};
                end
                state_d = RUN;
            end
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                qm1_d = step_qm1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_q == MD_OP_MUL) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                end else if (b_q == '0) begin
                    // Division by zero: all-ones quotient, dividend as remainder.
                    hi_d = a_q;
                    lo_d = '1;
`ifdef MULDIV_DIVZERO_EN
                    dz_d = 1'b1;
`endif
                end else begin
                    hi_d = sign_r_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    lo_d = sign_q_q ? -q_q : q_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            op_q     <= MD_OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIVZERO_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
    assign div_zero = dz_q;
`endif

endmodule
